// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bundle and opcode helpers for the ALU result stage.
package alu_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OPCODE_ADD = 3'b000;
    localparam opcode_t OPCODE_SUB = 3'b001;
    localparam opcode_t OPCODE_AND = 3'b010;
    localparam opcode_t OPCODE_OR  = 3'b011;
    localparam opcode_t OPCODE_XOR = 3'b100;
    localparam opcode_t OPCODE_SLL = 3'b101;
    localparam opcode_t OPCODE_SRL = 3'b110;
    localparam opcode_t OPCODE_SRA = 3'b111;

    typedef struct packed {
        logic zero;
        logic neg;
        logic is_shift;
    } alu_flags_t;

    // Only the left shift is reported as a shift; SRL/SRA are deliberately excluded.
    function automatic logic is_shift_op(input opcode_t op);
        return op == OPCODE_SLL;
    endfunction

endpackage

// File: rtl/alu_skid_buf2.sv
// Two-entry FIFO skid buffer on a flat packed entry; entry visible one cycle after push.
// in_ready is a flop (low only while both entries are held), so out_ready never reaches in_ready.
module alu_skid_buf2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign in_ready  = ready_q;
    assign out_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + 2'd1;
                2'b01:   count_next = count - 2'd1;
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 2'd0;
            ready_q <= 1'b1;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count   <= count_next;
            ready_q <= (count_next < 2'd2);
            // A flush drops both the stored entries and any same-cycle push/pop.
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registers ALU results with opcode/tag and push-time flags, hands them to writeback in order.
// One cycle push-to-output when empty; in_ready is registered via a 2-entry skid buffer.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_opcode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_opcode,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_is_shift,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        opcode_t          opcode;
        logic [TAG_W-1:0] tag;
        alu_flags_t       flags;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t     in_entry;
    entry_t     head;
    logic [ENTRY_W-1:0] head_bits;
    logic       pop;

    always_comb begin
        in_entry                = '0;
        in_entry.result         = in_result;
        in_entry.opcode         = in_opcode;
        in_entry.tag            = in_tag;
        in_entry.flags.zero     = (in_result == '0);
        in_entry.flags.neg      = in_result[WIDTH-1];
        in_entry.flags.is_shift = is_shift_op(in_opcode);
    end

    alu_skid_buf2 #(
        .W (ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_bits)
    );

    assign head         = entry_t'(head_bits);
    assign out_result   = head.result;
    assign out_opcode   = head.opcode;
    assign out_tag      = head.tag;
    assign out_zero     = head.flags.zero;
    assign out_neg      = head.flags.neg;
    assign out_is_shift = head.flags.is_shift;

    assign pop = out_valid & out_ready;

    // A handshake that coincides with flush still left the stage, so it is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (pop && (retired_cnt != {CNT_W{1'b1}})) begin
            retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a small queue model and explicit hand-computed checks.
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, out_ready;
    logic             in_ready, out_valid, out_zero, out_neg, out_is_shift;
    logic [WIDTH-1:0] in_result, out_result;
    logic [2:0]       in_opcode, out_opcode;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [CNT_W-1:0] retired_cnt;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic [2:0]       opcode;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t q[$];
    int   ret_model = 0;
    int   total = 0;
    int   bad = 0;

    alu_result_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_opcode(in_opcode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_opcode(out_opcode), .out_tag(out_tag),
        .out_zero(out_zero), .out_neg(out_neg), .out_is_shift(out_is_shift),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [2:0] op,
                         input logic [TAG_W-1:0] t);
        in_valid  = v;
        in_result = r;
        in_opcode = op;
        in_tag    = t;
    endtask

    // One clock: advance the model from the inputs presented, then compare all visible state.
    task automatic tick();
        bit   push, pop;
        ent_t e;
        push = in_valid && (q.size() < 2) && !rst;
        pop  = (q.size() != 0) && out_ready && !rst;
        e.result = in_result;
        e.opcode = in_opcode;
        e.tag    = in_tag;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            ret_model = 0;
        end else begin
            if (pop && ret_model < 15) ret_model++;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
            end
        end
        chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("m_retired", 64'(retired_cnt), 64'(ret_model));
        if (q.size() != 0) begin
            chk("m_result", 64'(out_result), 64'(q[0].result));
            chk("m_opcode", 64'(out_opcode), 64'(q[0].opcode));
            chk("m_tag", 64'(out_tag), 64'(q[0].tag));
            chk("m_zero", 64'(out_zero), 64'(q[0].result == 0));
            chk("m_neg", 64'(out_neg), 64'(q[0].result[WIDTH-1]));
            chk("m_shift", 64'(out_is_shift), 64'(q[0].opcode == 3'b101));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);

        // 1 reset
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_retired", 64'(retired_cnt), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_flags", 64'({out_zero, out_neg, out_is_shift}), 64'd0);

        // 2 single pass
        out_ready = 1'b1;
        drive(1'b1, 32'h0000_0010, 3'b101, 4'd3);
        tick();
        drive(1'b0, '0, '0, '0);
        chk("sp_valid", 64'(out_valid), 64'd1);
        chk("sp_result", 64'(out_result), 64'h10);
        chk("sp_tag", 64'(out_tag), 64'd3);
        chk("sp_flags", 64'({out_zero, out_neg, out_is_shift}), 64'b001);
        tick();
        chk("sp_retired", 64'(retired_cnt), 64'd1);
        chk("sp_empty", 64'(out_valid), 64'd0);

        // 3 back-pressure
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 3'b000, 4'd1);
        tick();
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h8000_0000, 3'b111, 4'd2);
        tick();
        chk("bp_rdy2", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h5, 3'b101, 4'd4);
        tick();
        chk("bp_ignored_rdy", 64'(in_ready), 64'd0);
        chk("bp_hold_result", 64'(out_result), 64'h0);
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        chk("bp_head0_zero", 64'({out_zero, out_neg, out_tag}), 64'h21);
        tick();
        chk("bp_head1_result", 64'(out_result), 64'h8000_0000);
        chk("bp_head1_neg", 64'({out_zero, out_neg, out_is_shift}), 64'b010);
        chk("bp_head1_tag", 64'(out_tag), 64'd2);
        tick();
        chk("bp_drained", 64'(out_valid), 64'd0);
        chk("bp_retired", 64'(retired_cnt), 64'd3);

        // 4 streaming
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            tick();
            chk("st_in_ready", 64'(in_ready), 64'd1);
        end
        drive(1'b0, '0, '0, '0);
        tick();
        chk("st_retired_sat", 64'(retired_cnt), 64'd15);

        // 5 flush with two held and a simultaneous push
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 3'b001, 4'd7);
        tick();
        drive(1'b1, 32'hAAAA_0002, 3'b010, 4'd8);
        tick();
        drive(1'b1, 32'hBBBB_0003, 3'b011, 4'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("fl_stays_empty", 64'(out_valid), 64'd0);

        // 6 saturation then mid-stream reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(i + 1), 3'b000, 4'(i));
            tick();
        end
        drive(1'b0, '0, '0, '0);
        tick();
        chk("sat_retired", 64'(retired_cnt), 64'd15);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 3'b101, 4'(i));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_ready", 64'(in_ready), 64'd1);
        chk("mr_retired", 64'(retired_cnt), 64'd0);
        chk("mr_result", 64'(out_result), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
